lemmings_fsm_array: RTL and testbench
=====================================

Name: lemmings_fsm_array

Overview:
- Parametrised successor of the single-lemming walker FSM.
- Runs NUM_LEM independent lemming state machines in parallel from per-lane input vectors.
- Fall-death threshold and dig-duration limit are configurable; each lane has a sticky dead flag, and the block reports a live-lemming count.
- Sits in the Finite-State-Machine exercise set as the reusable, multi-instance form of the walker.

Parameters:
- NUM_LEM, 4: number of independent lemming lanes (1..32).
- FALL_LIMIT, 20: maximum survivable fall length in cycles; landing after a longer fall kills the lane. 0 = falls never kill.
- DIG_LIMIT, 0: maximum consecutive digging cycles before the lane stops digging and walks on. 0 = unlimited.
- CNT_W, 6: width of the per-lane fall and dig counters; must satisfy 2^CNT_W > max(FALL_LIMIT, DIG_LIMIT).

Ports:
- clk  in  1  rising-edge clock.
- areset_n  in  1  reset, asynchronous, active-low; all lanes return to walk-left.
- bump_left  in  NUM_LEM  per-lane left-side obstacle.
- bump_right  in  NUM_LEM  per-lane right-side obstacle.
- ground  in  NUM_LEM  per-lane ground present.
- dig  in  NUM_LEM  per-lane dig command.
- walk_left  out  NUM_LEM  lane walking left.
- walk_right  out  NUM_LEM  lane walking right.
- aaah  out  NUM_LEM  lane falling.
- digging  out  NUM_LEM  lane digging.
- dead  out  NUM_LEM  lane splattered; sticky until reset.
- alive_count  out  $clog2(NUM_LEM+1)  number of lanes with dead=0.

Behaviour:
- Lanes are fully independent; lane i uses only bit i of each input vector.
- Per-lane states: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, DEAD.
- Outputs are a Moore decode of current state:
  - walk_left = WALK_L; walk_right = WALK_R.
  - aaah = FALL_L or FALL_R; digging = DIG_L or DIG_R; dead = DEAD.
  - Exactly one output bit per lane is high.
- Reset (areset_n=0, asynchronous): every lane goes to WALK_L and all counters clear. Outputs: walk_left all ones, all others zero, alive_count = NUM_LEM.
- Reset mid-fall or mid-dig aborts immediately with no death.
- Transition priority in WALK_x: ground=0 > dig=1 > bump > stay.
  - WALK_L: ground=0 -> FALL_L; dig=1 -> DIG_L; bump_left=1 -> WALK_R; else WALK_L.
  - WALK_R mirrors WALK_L with bump_right.
  - Bump on the side opposite the walking direction is ignored.
  - Simultaneous bump_left and bump_right while walking: the lane reverses direction.
- FALL_x:
  - dig and bump are ignored.
  - fall_cnt increments each FALL cycle and saturates at FALL_LIMIT+1.
  - ground=1 with fall length L > FALL_LIMIT (FALL_LIMIT≠0) -> DEAD; otherwise -> WALK_x, keeping the pre-fall direction.
  - L is the number of cycles aaah was high.
- DIG_x:
  - bump and dig are ignored; dig_cnt increments each DIG cycle.
  - ground=0 -> FALL_x, with fall_cnt starting at 0.
  - DIG_LIMIT≠0 and the DIG_LIMIT-th dig cycle completes with ground=1 -> WALK_x, same direction. dig high that cycle does not re-enter dig; a new dig needs dig sampled in WALK_x.
- DEAD: absorbing; only reset exits.
- Counters clear on any entry to a non-counting state.
- alive_count is combinational: NUM_LEM minus popcount(dead). No added latency.
- All state changes take effect one clock after the inputs are sampled.

Test Plan:
- Reset: NUM_LEM=4, hold areset_n=0, then release -> walk_left=4'b1111, dead=0, alive_count=4. Assert areset_n=0 mid-cycle -> outputs return to this value immediately, without waiting for clk.
- Bump: lane 0 bump_left=1 for 1 cycle -> next cycle walk_right[0]=1. Lane 1 bump_right=1 while walking left -> no change. Lane 2 both bumps -> reverses.
- Fall boundary, FALL_LIMIT=20:
  - lane 0 ground=0 for 20 cycles -> lands WALK_L, dead[0]=0.
  - lane 1 ground=0 for 21 cycles -> DEAD, alive_count=3.
  - lane 1 then stays dead regardless of inputs.
- Dig then fall: lane 3 dig=1 while walking right -> DIG_R; ground=0 -> aaah[3]=1 for 5 cycles; ground=1 -> walk_right[3]=1.
- Dig limit, DIG_LIMIT=8: hold dig=1, ground=1 -> digging high exactly 8 cycles, then walk_left=1. With dig still held, it re-enters DIG_L on the following cycle.
- Priority: ground=0, dig=1 and bump_left=1 together in WALK_L -> FALL_L. FALL_LIMIT=0 with a 60-cycle fall -> lands alive, fall_cnt saturates without wrap.

Source files
------------

// File: rtl/lemmings_fsm_array_if.sv
// Per-lane lemming stimulus and status bundle shared between the array and its driver.
// All vectors are NUM_LEM wide, bit i belongs to lane i.
interface lemmings_fsm_array_if #(
  parameter int NUM_LEM = 4
);
  localparam int AW = $clog2(NUM_LEM + 1);

  logic [NUM_LEM-1:0] bump_left;
  logic [NUM_LEM-1:0] bump_right;
  logic [NUM_LEM-1:0] ground;
  logic [NUM_LEM-1:0] dig;
  logic [NUM_LEM-1:0] walk_left;
  logic [NUM_LEM-1:0] walk_right;
  logic [NUM_LEM-1:0] aaah;
  logic [NUM_LEM-1:0] digging;
  logic [NUM_LEM-1:0] dead;
  logic [AW-1:0]      alive_count;

  modport master (
    output bump_left, bump_right, ground, dig,
    input  walk_left, walk_right, aaah, digging, dead, alive_count
  );

  modport slave (
    input  bump_left, bump_right, ground, dig,
    output walk_left, walk_right, aaah, digging, dead, alive_count
  );
endinterface

// File: rtl/lemmings_fsm_array.sv
// NUM_LEM independent lemming walker FSMs with fall-death threshold, optional dig limit,
// sticky per-lane death and a combinational live-lemming count.
//
// state  | meaning
// -------+--------------------------------------------------------------
// WALK_L | walking left, bump_left reverses
// WALK_R | walking right, bump_right reverses
// FALL_L | falling, lands walking left (or dies after a long fall)
// FALL_R | falling, lands walking right (or dies after a long fall)
// DIG_L  | digging, resumes walking left
// DIG_R  | digging, resumes walking right
// DEAD   | splattered, held until reset
module lemmings_fsm_array #(
  parameter int NUM_LEM    = 4,
  parameter int FALL_LIMIT = 20,
  parameter int DIG_LIMIT  = 0,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  areset_n,
  lemmings_fsm_array_if.slave   lem
);
  localparam int AW = $clog2(NUM_LEM + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALL  = '1;
  localparam logic [CNT_W-1:0] FALL_MAX = CNT_W'(FALL_LIMIT);
  localparam logic [CNT_W-1:0] FALL_SAT = CNT_W'(FALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] DIG_LAST = (DIG_LIMIT == 0) ? '0 : CNT_W'(DIG_LIMIT - 1);

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    DEAD   = 3'd6
  } lem_state_t;

  lem_state_t       state     [NUM_LEM];
  lem_state_t       state_nxt [NUM_LEM];
  logic [CNT_W-1:0] fall_cnt     [NUM_LEM];
  logic [CNT_W-1:0] fall_cnt_nxt [NUM_LEM];
  logic [CNT_W-1:0] dig_cnt      [NUM_LEM];
  logic [CNT_W-1:0] dig_cnt_nxt  [NUM_LEM];

  logic [NUM_LEM-1:0] walk_left_v;
  logic [NUM_LEM-1:0] walk_right_v;
  logic [NUM_LEM-1:0] aaah_v;
  logic [NUM_LEM-1:0] digging_v;
  logic [NUM_LEM-1:0] dead_v;
  logic [AW-1:0]      dead_cnt;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_LEM; i++) begin
        state[i]    <= WALK_L;
        fall_cnt[i] <= '0;
        dig_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEM; i++) begin
        state[i]    <= state_nxt[i];
        fall_cnt[i] <= fall_cnt_nxt[i];
        dig_cnt[i]  <= dig_cnt_nxt[i];
      end
    end
  end

  // Counters default to zero so any exit from FALL/DIG clears them.
  always_comb begin
    for (int i = 0; i < NUM_LEM; i++) begin
      state_nxt[i]    = state[i];
      fall_cnt_nxt[i] = '0;
      dig_cnt_nxt[i]  = '0;
      case (state[i])
        WALK_L: begin
          if (!lem.ground[i])        state_nxt[i] = FALL_L;
          else if (lem.dig[i])       state_nxt[i] = DIG_L;
          else if (lem.bump_left[i]) state_nxt[i] = WALK_R;
        end
        WALK_R: begin
          if (!lem.ground[i])         state_nxt[i] = FALL_R;
          else if (lem.dig[i])        state_nxt[i] = DIG_R;
          else if (lem.bump_right[i]) state_nxt[i] = WALK_L;
        end
        FALL_L, FALL_R: begin
          // fall_cnt holds completed fall cycles, so the landing cycle makes L = fall_cnt + 1.
          if (lem.ground[i]) begin
            if ((FALL_LIMIT != 0) && ((fall_cnt[i] == FALL_MAX) || (fall_cnt[i] == FALL_SAT)))
              state_nxt[i] = DEAD;
            else
              state_nxt[i] = (state[i] == FALL_L) ? WALK_L : WALK_R;
          end else begin
            fall_cnt_nxt[i] = (fall_cnt[i] == FALL_SAT) ? fall_cnt[i] : fall_cnt[i] + CNT_ONE;
          end
        end
        DIG_L, DIG_R: begin
          if (!lem.ground[i]) begin
            state_nxt[i] = (state[i] == DIG_L) ? FALL_L : FALL_R;
          end else if ((DIG_LIMIT != 0) && (dig_cnt[i] == DIG_LAST)) begin
            state_nxt[i] = (state[i] == DIG_L) ? WALK_L : WALK_R;
          end else begin
            dig_cnt_nxt[i] = (dig_cnt[i] == CNT_ALL) ? dig_cnt[i] : dig_cnt[i] + CNT_ONE;
          end
        end
        DEAD:    state_nxt[i] = DEAD;
        default: state_nxt[i] = WALK_L;
      endcase
    end
  end

  always_comb begin
    walk_left_v  = '0;
    walk_right_v = '0;
    aaah_v       = '0;
    digging_v    = '0;
    dead_v       = '0;
    dead_cnt     = '0;
    for (int i = 0; i < NUM_LEM; i++) begin
      walk_left_v[i]  = (state[i] == WALK_L);
      walk_right_v[i] = (state[i] == WALK_R);
      aaah_v[i]       = (state[i] == FALL_L) || (state[i] == FALL_R);
      digging_v[i]    = (state[i] == DIG_L) || (state[i] == DIG_R);
      dead_v[i]       = (state[i] == DEAD);
      dead_cnt        = dead_cnt + AW'(dead_v[i]);
    end
  end

  assign lem.walk_left   = walk_left_v;
  assign lem.walk_right  = walk_right_v;
  assign lem.aaah        = aaah_v;
  assign lem.digging     = digging_v;
  assign lem.dead        = dead_v;
  assign lem.alive_count = AW'(NUM_LEM) - dead_cnt;
endmodule

// File: tb/tb_lemmings_fsm_array.sv
// Directed bench for lemmings_fsm_array: dut_a uses FALL_LIMIT=20/DIG_LIMIT=8,
// dut_b uses FALL_LIMIT=0/DIG_LIMIT=0 for the never-kill and unlimited-dig cases.
module tb_lemmings_fsm_array;
  localparam int N = 4;

  logic clk = 1'b0;
  logic areset_n = 1'b0;

  lemmings_fsm_array_if #(.NUM_LEM(N)) bus_a ();
  lemmings_fsm_array_if #(.NUM_LEM(N)) bus_b ();

  lemmings_fsm_array #(.NUM_LEM(N), .FALL_LIMIT(20), .DIG_LIMIT(8), .CNT_W(6)) dut_a (
    .clk(clk), .areset_n(areset_n), .lem(bus_a)
  );
  lemmings_fsm_array #(.NUM_LEM(N), .FALL_LIMIT(0), .DIG_LIMIT(0), .CNT_W(6)) dut_b (
    .clk(clk), .areset_n(areset_n), .lem(bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bl, br, gr, dg;
    logic [3:0] wl, wr, fa, di, de;
    logic [2:0] alive;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.bump_left = '0; bus_a.bump_right = '0; bus_a.ground = '1; bus_a.dig = '0;
  endtask

  task automatic idle_b();
    bus_b.bump_left = '0; bus_b.bump_right = '0; bus_b.ground = '1; bus_b.dig = '0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_wl"},    32'(bus_a.walk_left),   32'h0000000f);
    check({tag, "_wr"},    32'(bus_a.walk_right),  32'h0);
    check({tag, "_aaah"},  32'(bus_a.aaah),        32'h0);
    check({tag, "_dig"},   32'(bus_a.digging),     32'h0);
    check({tag, "_dead"},  32'(bus_a.dead),        32'h0);
    check({tag, "_alive"}, 32'(bus_a.alive_count), 32'd4);
  endtask

  int n0, n1, n3, nd;
  logic [3:0] r;

  initial begin
    vecs[0] = '{4'b0101, 4'b0110, 4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 3'd4};
    vecs[1] = '{4'b0101, 4'b0100, 4'b1111, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 3'd4};
    vecs[2] = '{4'b0010, 4'b0001, 4'b1101, 4'b0010, 4'b1101, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 3'd4};
    vecs[3] = '{4'b0000, 4'b0000, 4'b1111, 4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'd4};
    vecs[4] = '{4'b1000, 4'b1000, 4'b1111, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'd4};
    vecs[5] = '{4'b0001, 4'b0000, 4'b1111, 4'b0001, 4'b0110, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 3'd4};

    idle_a();
    idle_b();
    #12;
    check_reset_a("rst_hold");
    check("rst_hold_b_wl",    32'(bus_b.walk_left),   32'h0000000f);
    check("rst_hold_b_alive", 32'(bus_b.alive_count), 32'd4);
    @(posedge clk);
    #1 areset_n = 1'b1;
    tick();
    check_reset_a("rst_rel");

    // Bump handling, priority and dig entry, one clock per record.
    for (int i = 0; i < 6; i++) begin
      bus_a.bump_left  = vecs[i].bl;
      bus_a.bump_right = vecs[i].br;
      bus_a.ground     = vecs[i].gr;
      bus_a.dig        = vecs[i].dg;
      tick();
      check($sformatf("vec%0d_wl", i),    32'(bus_a.walk_left),   32'(vecs[i].wl));
      check($sformatf("vec%0d_wr", i),    32'(bus_a.walk_right),  32'(vecs[i].wr));
      check($sformatf("vec%0d_aaah", i),  32'(bus_a.aaah),        32'(vecs[i].fa));
      check($sformatf("vec%0d_dig", i),   32'(bus_a.digging),     32'(vecs[i].di));
      check($sformatf("vec%0d_dead", i),  32'(bus_a.dead),        32'(vecs[i].de));
      check($sformatf("vec%0d_alive", i), 32'(bus_a.alive_count), 32'(vecs[i].alive));
    end

    // Asynchronous reset mid-dig, sampled without any clock edge.
    idle_a();
    #2 areset_n = 1'b0;
    #1;
    check_reset_a("rst_async");
    #3 areset_n = 1'b1;
    tick();
    check_reset_a("rst_async_rel");

    // Fall boundary: lane 0 falls 20 cycles, lane 1 falls 21 cycles.
    n0 = 0; n1 = 0;
    for (int k = 0; k < 22; k++) begin
      bus_a.ground = 4'b1111;
      if (k < 20) bus_a.ground[0] = 1'b0;
      if (k < 21) bus_a.ground[1] = 1'b0;
      tick();
      if (bus_a.aaah[0]) n0++;
      if (bus_a.aaah[1]) n1++;
      if (k == 20) begin
        check("fall20_lane0_wl",   32'(bus_a.walk_left[0]), 32'd1);
        check("fall20_lane1_aaah", 32'(bus_a.aaah[1]),      32'd1);
      end
    end
    check("fall20_len",   32'(n0), 32'd20);
    check("fall21_len",   32'(n1), 32'd21);
    check("fall21_dead",  32'(bus_a.dead),        32'h2);
    check("fall21_alive", 32'(bus_a.alive_count), 32'd3);
    check("fall21_wl",    32'(bus_a.walk_left),   32'hd);

    for (int k = 0; k < 8; k++) begin
      r = 4'($urandom);
      bus_a.bump_left  = r & 4'b0010;
      r = 4'($urandom);
      bus_a.bump_right = r & 4'b0010;
      r = 4'($urandom);
      bus_a.ground     = (r & 4'b0010) | 4'b1101;
      r = 4'($urandom);
      bus_a.dig        = r & 4'b0010;
      tick();
      check($sformatf("sticky%0d_dead", k),  32'(bus_a.dead),        32'h2);
      check($sformatf("sticky%0d_alive", k), 32'(bus_a.alive_count), 32'd3);
    end
    idle_a();

    // Lane 3: turn right, dig, fall 5 cycles, land facing right.
    bus_a.bump_left = 4'b1000;
    tick();
    check("l3_turn_wr", 32'(bus_a.walk_right[3]), 32'd1);
    bus_a.bump_left = 4'b0000;
    bus_a.dig       = 4'b1000;
    tick();
    check("l3_dig_r", 32'(bus_a.digging[3]), 32'd1);
    bus_a.dig = 4'b0000;
    n3 = 0;
    for (int k = 0; k < 6; k++) begin
      bus_a.ground = (k < 5) ? 4'b0111 : 4'b1111;
      tick();
      if (bus_a.aaah[3]) n3++;
    end
    check("l3_fall_len", 32'(n3), 32'd5);
    check("l3_land_wr",  32'(bus_a.walk_right[3]), 32'd1);
    check("l3_alive",    32'(bus_a.alive_count),   32'd3);

    // Lane 2: dig limit of 8 with dig held, then re-entry.
    bus_a.dig = 4'b0100;
    nd = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (bus_a.digging[2]) nd++;
    end
    check("diglim_len",     32'(nd), 32'd8);
    check("diglim_walk_l",  32'(bus_a.walk_left[2]), 32'd1);
    tick();
    check("diglim_reenter", 32'(bus_a.digging[2]), 32'd1);
    idle_a();

    // dut_b: 60-cycle fall never kills, dig with no limit keeps digging.
    n0 = 0; nd = 0;
    bus_b.dig = 4'b0010;
    for (int k = 0; k < 61; k++) begin
      bus_b.ground = (k < 60) ? 4'b1110 : 4'b1111;
      tick();
      if (bus_b.aaah[0]) n0++;
      if (bus_b.digging[1]) nd++;
    end
    check("b_fall_len",   32'(n0), 32'd60);
    check("b_land_wl",    32'(bus_b.walk_left[0]), 32'd1);
    check("b_dead",       32'(bus_b.dead),         32'h0);
    check("b_alive",      32'(bus_b.alive_count),  32'd4);
    check("b_dig_len",    32'(nd), 32'd61);
    check("b_dig_still",  32'(bus_b.digging),      32'h2);
    idle_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
